// File: rtl/edge_color_stats.sv
// Per-frame max/min/avg background colour on the four edges of a
// square sprite window, published atomically with a one-cycle strobe.
module edge_color_stats #(
  parameter int SIZE_LOG2 = 4,
  parameter int COLOR_W   = 8,
  parameter int COORD_W   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic                   frame_end,
  input  logic                   pix_valid,
  input  logic [COORD_W-1:0]     pix_x,
  input  logic [COORD_W-1:0]     pix_y,
  input  logic [COLOR_W-1:0]     R_bg,
  input  logic [COLOR_W-1:0]     G_bg,
  input  logic [COLOR_W-1:0]     B_bg,
  input  logic [COORD_W-1:0]     ancora_sp_X,
  input  logic [COORD_W-1:0]     ancora_sp_Y,
  output logic [12*COLOR_W-1:0]  stat_max,
  output logic [12*COLOR_W-1:0]  stat_min,
  output logic [12*COLOR_W-1:0]  stat_avg,
  output logic [3:0]             edge_ok,
  output logic                   stats_valid,
  output logic                   busy
);

  localparam int N   = 1 << SIZE_LOG2;
  localparam int SW  = COLOR_W + SIZE_LOG2 + 1;
  localparam int CNW = SIZE_LOG2 + 2;
  localparam int AW  = COORD_W + 1;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  typedef logic [3:0][2:0][COLOR_W-1:0] col_t;
  typedef logic [3:0][2:0][SW-1:0]      sum_t;
  typedef logic [3:0][CNW-1:0]          cnt_t;

  logic [0:0]         state_q, state_d;
  logic [COORD_W-1:0] ax_q, ay_q;
  col_t               max_q, max_d, min_q, min_d;
  sum_t               sum_q, sum_d;
  cnt_t               cnt_q, cnt_d;
  col_t               fmax, fmin;
  sum_t               fsum;
  cnt_t               fcnt;
  col_t               pmax_q, pmax_d, pmin_q, pmin_d;
  col_t               pavg_q, pavg_d;
  logic [3:0]         ok_q, ok_d;
  logic               valid_q;

  logic [AW-1:0]          x, y, axl, ayl, axh, ayh;
  logic                   inx, iny, upd, publish;
  logic [3:0]             hit;
  logic [2:0][COLOR_W-1:0] pix;
  logic [COLOR_W-1:0]     bmax, bmin;
  logic [SW-1:0]          bsum;
  logic [CNW-1:0]         bcnt;
  logic [COLOR_W:0]       avgw;

  // Membership uses the live anchor on frame_start, else the latched one.
  always_comb begin
    x   = {1'b0, pix_x};
    y   = {1'b0, pix_y};
    axl = {1'b0, frame_start ? ancora_sp_X : ax_q};
    ayl = {1'b0, frame_start ? ancora_sp_Y : ay_q};
    axh = axl + AW'(N - 1);
    ayh = ayl + AW'(N - 1);
    inx = (x >= axl) && (x <= axh);
    iny = (y >= ayl) && (y <= ayh);
    hit[0] = (y == ayl) && inx;
    hit[1] = (y == ayh) && inx;
    hit[2] = (x == axl) && iny;
    hit[3] = (x == axh) && iny;
    pix[0] = R_bg;
    pix[1] = G_bg;
    pix[2] = B_bg;
    upd = pix_valid && (state_q == COLLECT || frame_start);
    publish = (state_q == COLLECT) && frame_end;
  end

  always_comb begin
    max_d = max_q;
    min_d = min_q;
    sum_d = sum_q;
    cnt_d = cnt_q;
    bmax  = '0;
    bmin  = '1;
    bsum  = '0;
    bcnt  = '0;
    for (int e = 0; e < 4; e++) begin
      bcnt = frame_start ? '0 : cnt_q[e];
      cnt_d[e] = bcnt;
      if (upd && hit[e] && (bcnt != '1))
        cnt_d[e] = bcnt + CNW'(1);
      for (int c = 0; c < 3; c++) begin
        bmax = frame_start ? '0 : max_q[e][c];
        bmin = frame_start ? '1 : min_q[e][c];
        bsum = frame_start ? '0 : sum_q[e][c];
        max_d[e][c] = bmax;
        min_d[e][c] = bmin;
        sum_d[e][c] = bsum;
        if (upd && hit[e]) begin
          if (pix[e == 0 ? c : c] > bmax)
            max_d[e][c] = pix[c];
          if (pix[c] < bmin)
            min_d[e][c] = pix[c];
          sum_d[e][c] = bsum + SW'(pix[c]);
        end
      end
    end
  end

  // The published frame excludes a coincident frame_start pixel.
  always_comb begin
    fmax   = frame_start ? max_q : max_d;
    fmin   = frame_start ? min_q : min_d;
    fsum   = frame_start ? sum_q : sum_d;
    fcnt   = frame_start ? cnt_q : cnt_d;
    pmax_d = fmax;
    pmin_d = '0;
    pavg_d = '0;
    ok_d   = '0;
    avgw   = '0;
    for (int e = 0; e < 4; e++) begin
      ok_d[e] = (fcnt[e] == CNW'(N));
      for (int c = 0; c < 3; c++) begin
        pmin_d[e][c] = (fcnt[e] == '0) ? '0 : fmin[e][c];
        avgw = fsum[e][c][SW-1:SIZE_LOG2];
        pavg_d[e][c] = avgw[COLOR_W] ? '1 : avgw[COLOR_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (frame_start)
      state_d = COLLECT;
    else if (publish)
      state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ax_q    <= '0;
      ay_q    <= '0;
      max_q   <= '0;
      min_q   <= '1;
      sum_q   <= '0;
      cnt_q   <= '0;
      pmax_q  <= '0;
      pmin_q  <= '0;
      pavg_q  <= '0;
      ok_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (frame_start) begin
        ax_q <= ancora_sp_X;
        ay_q <= ancora_sp_Y;
      end
      max_q   <= max_d;
      min_q   <= min_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      valid_q <= publish;
      if (publish) begin
        pmax_q <= pmax_d;
        pmin_q <= pmin_d;
        pavg_q <= pavg_d;
        ok_q   <= ok_d;
      end
    end
  end

  assign stat_max    = pmax_q;
  assign stat_min    = pmin_q;
  assign stat_avg    = pavg_q;
  assign edge_ok     = ok_q;
  assign stats_valid = valid_q;
  assign busy        = (state_q == COLLECT);

endmodule

// File: tb/tb_edge_color_stats.sv
// Bench for edge_color_stats: directed table, hand sequences and
// random frames against a per-edge reference model.
module tb_edge_color_stats;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start, frame_end, pix_valid;
  logic [9:0]  pix_x, pix_y, ancora_sp_X, ancora_sp_Y;
  logic [7:0]  R_bg, G_bg, B_bg;
  logic [95:0] stat_max, stat_min, stat_avg;
  logic [3:0]  edge_ok;
  logic        stats_valid, busy;

  always #5 clk = ~clk;

  edge_color_stats dut (
    .clk(clk), .rst(rst),
    .frame_start(frame_start), .frame_end(frame_end),
    .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y),
    .R_bg(R_bg), .G_bg(G_bg), .B_bg(B_bg),
    .ancora_sp_X(ancora_sp_X), .ancora_sp_Y(ancora_sp_Y),
    .stat_max(stat_max), .stat_min(stat_min),
    .stat_avg(stat_avg), .edge_ok(edge_ok),
    .stats_valid(stats_valid), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  int   m_mx[4][3], m_mn[4][3], m_sum[4][3], m_cnt[4];
  bit   m_collect;
  int   m_ax, m_ay;
  logic [95:0] e_max, e_min, e_avg;
  logic [3:0]  e_ok;
  logic        e_valid;

  typedef struct {
    string nm;
    int ax, ay, x0, x1, y0, y1, r, g, b;
    int sx1, sy1, sr1, sx2, sy2, sr2;
    logic [3:0] ok;
    logic [7:0] tmax, tmin, tavg, lmax, rmax, bmax;
  } scn_t;

  scn_t tbl[4];

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] fld(input logic [95:0] v,
                                     input int e, input int c);
    return v[(3*e+c)*8 +: 8];
  endfunction

  function automatic bit on_edge(input int e, input int x, input int y,
                                 input int ax, input int ay);
    bit inx = (x >= ax) && (x <= ax + N - 1);
    bit iny = (y >= ay) && (y <= ay + N - 1);
    case (e)
      0: return (y == ay) && inx;
      1: return (y == ay + N - 1) && inx;
      2: return (x == ax) && iny;
      default: return (x == ax + N - 1) && iny;
    endcase
  endfunction

  task automatic m_clear();
    for (int e = 0; e < 4; e++) begin
      m_cnt[e] = 0;
      for (int c = 0; c < 3; c++) begin
        m_mx[e][c] = 0;
        m_mn[e][c] = 255;
        m_sum[e][c] = 0;
      end
    end
  endtask

  task automatic m_add(input int x, input int y, input int r,
                       input int g, input int b, input int ax,
                       input int ay);
    int v[3];
    v[0] = r; v[1] = g; v[2] = b;
    for (int e = 0; e < 4; e++)
      if (on_edge(e, x, y, ax, ay)) begin
        if (m_cnt[e] < 63) m_cnt[e]++;
        for (int c = 0; c < 3; c++) begin
          if (v[c] > m_mx[e][c]) m_mx[e][c] = v[c];
          if (v[c] < m_mn[e][c]) m_mn[e][c] = v[c];
          m_sum[e][c] = (m_sum[e][c] + v[c]) % 8192;
        end
      end
  endtask

  task automatic m_pub();
    int a;
    for (int e = 0; e < 4; e++) begin
      e_ok[e] = (m_cnt[e] == N);
      for (int c = 0; c < 3; c++) begin
        a = m_sum[e][c] / N;
        if (a > 255) a = 255;
        e_max[(3*e+c)*8 +: 8] = 8'(m_mx[e][c]);
        e_min[(3*e+c)*8 +: 8] = (m_cnt[e] == 0) ? 8'd0 : 8'(m_mn[e][c]);
        e_avg[(3*e+c)*8 +: 8] = 8'(a);
      end
    end
  endtask

  task automatic check_all();
    chk("stats_valid", 96'(stats_valid), 96'(e_valid));
    chk("busy", 96'(busy), 96'(m_collect));
    chk("stat_max", stat_max, e_max);
    chk("stat_min", stat_min, e_min);
    chk("stat_avg", stat_avg, e_avg);
    chk("edge_ok", 96'(edge_ok), 96'(e_ok));
  endtask

  task automatic cyc(input bit fs, input bit fe, input bit pv,
                     input int x, input int y, input int r,
                     input int g, input int b, input int ax,
                     input int ay);
    bit pub;
    frame_start = fs; frame_end = fe; pix_valid = pv;
    pix_x = 10'(x); pix_y = 10'(y);
    R_bg = 8'(r); G_bg = 8'(g); B_bg = 8'(b);
    ancora_sp_X = 10'(ax); ancora_sp_Y = 10'(ay);
    pub = fe && m_collect;
    if (!fs && m_collect && pv) m_add(x, y, r, g, b, m_ax, m_ay);
    if (pub) m_pub();
    e_valid = pub;
    if (fs) begin
      m_clear();
      m_ax = ax; m_ay = ay;
      if (pv) m_add(x, y, r, g, b, ax, ay);
      m_collect = 1;
    end else if (pub) begin
      m_collect = 0;
    end
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_scn(input scn_t s);
    int r;
    bit last;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, s.ax, s.ay);
    for (int y = s.y0; y <= s.y1; y++)
      for (int x = s.x0; x <= s.x1; x++) begin
        r = s.r;
        if (x == s.sx1 && y == s.sy1) r = s.sr1;
        if (x == s.sx2 && y == s.sy2) r = s.sr2;
        last = (x == s.x1) && (y == s.y1);
        cyc(0, last, 1, x, y, r, s.g, s.b,
            int'($urandom_range(0, 1023)),
            int'($urandom_range(0, 1023)));
      end
    chk({s.nm, " edge_ok"}, 96'(edge_ok), 96'(s.ok));
    chk({s.nm, " top_max_r"}, 96'(fld(stat_max, 0, 0)), 96'(s.tmax));
    chk({s.nm, " top_min_r"}, 96'(fld(stat_min, 0, 0)), 96'(s.tmin));
    chk({s.nm, " top_avg_r"}, 96'(fld(stat_avg, 0, 0)), 96'(s.tavg));
    chk({s.nm, " left_max_r"}, 96'(fld(stat_max, 2, 0)), 96'(s.lmax));
    chk({s.nm, " right_max_r"}, 96'(fld(stat_max, 3, 0)), 96'(s.rmax));
    chk({s.nm, " bot_max_r"}, 96'(fld(stat_max, 1, 0)), 96'(s.bmax));
    idle();
  endtask

  task automatic rand_frame();
    int ox, oy, ax, ay, x, y;
    bit fs, fe, last;
    ox = $urandom_range(0, 1) ? 984 : 0;
    oy = $urandom_range(0, 1) ? 992 : 0;
    ax = ox + $urandom_range(0, 39);
    ay = oy + $urandom_range(0, 31);
    for (int i = 0; i < 40 * 32; i++) begin
      x = ox + i % 40;
      y = oy + i / 40;
      last = (i == 40 * 32 - 1);
      fs = (i == 0) || ($urandom_range(0, 399) == 0);
      fe = last || ($urandom_range(0, 599) == 0);
      if (fs && i != 0) begin
        ax = ox + $urandom_range(0, 39);
        ay = oy + $urandom_range(0, 31);
      end
      cyc(fs, fe, $urandom_range(0, 4) != 0, x, y,
          $urandom_range(0, 255), $urandom_range(0, 255),
          $urandom_range(0, 255),
          fs ? ax : int'($urandom_range(0, 1023)),
          fs ? ay : int'($urandom_range(0, 1023)));
    end
    idle();
  endtask

  initial begin
    tbl[0] = '{"full", 100, 50, 96, 119, 46, 69, 'h40, 'h80, 'hC0,
               1023, 1023, 0, 1023, 1023, 0,
               4'b1111, 'h40, 'h40, 'h40, 'h40, 'h40, 'h40};
    tbl[1] = '{"extreme", 100, 50, 96, 119, 46, 69, 'h20, 'h20, 'h20,
               105, 50, 'hFF, 110, 50, 'h00,
               4'b1111, 'hFF, 'h00, 'h2B, 'h20, 'h20, 'h20};
    tbl[2] = '{"corner", 100, 50, 96, 119, 46, 69, 'h20, 'h20, 'h20,
               100, 50, 'hF0, 1023, 1023, 0,
               4'b1111, 'hF0, 'h20, 'h2D, 'hF0, 'h20, 'h20};
    tbl[3] = '{"clipped", 630, 50, 620, 639, 46, 69, 'h30, 'h50, 'h70,
               1023, 1023, 0, 1023, 1023, 0,
               4'b0100, 'h30, 'h30, 'h1E, 'h30, 'h00, 'h30};

    rst = 1'b1;
    frame_start = 0; frame_end = 0; pix_valid = 0;
    pix_x = 0; pix_y = 0; R_bg = 0; G_bg = 0; B_bg = 0;
    ancora_sp_X = 0; ancora_sp_Y = 0;
    m_clear();
    m_collect = 0; m_ax = 0; m_ay = 0;
    e_max = '0; e_min = '0; e_avg = '0; e_ok = '0; e_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    idle();

    foreach (tbl[i]) run_scn(tbl[i]);

    // Restart mid-frame: first frame discarded.
    cyc(1, 0, 1, 10, 10, 'h11, 0, 0, 10, 10);
    for (int x = 11; x < 26; x++)
      cyc(0, 0, 1, x, 10, 'h11, 0, 0, 0, 0);
    cyc(1, 0, 1, 10, 10, 'h77, 0, 0, 10, 10);
    chk("restart no_strobe", 96'(stats_valid), 96'(0));
    cyc(0, 1, 1, 11, 10, 'h22, 0, 0, 500, 500);
    chk("restart valid", 96'(stats_valid), 96'(1));
    chk("restart top_max", 96'(fld(stat_max, 0, 0)), 96'('h77));
    chk("restart top_min", 96'(fld(stat_min, 0, 0)), 96'('h22));
    chk("restart top_avg", 96'(fld(stat_avg, 0, 0)), 96'('h09));
    idle();

    // Coincident frame_start/frame_end while collecting.
    cyc(1, 0, 1, 12, 10, 'h33, 0, 0, 10, 10);
    cyc(1, 1, 1, 10, 10, 'h55, 0, 0, 10, 10);
    chk("coinc valid", 96'(stats_valid), 96'(1));
    chk("coinc busy", 96'(busy), 96'(1));
    chk("coinc old_max", 96'(fld(stat_max, 0, 0)), 96'('h33));
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("coinc new_max", 96'(fld(stat_max, 0, 0)), 96'('h55));
    chk("coinc idle", 96'(busy), 96'(0));
    idle();

    // Repeated pixel drives the average into saturation.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 20, 20);
    repeat (20) cyc(0, 0, 1, 20, 20, 'hFF, 'hFF, 'hFF, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("sat top_avg", 96'(fld(stat_avg, 0, 0)), 96'('hFF));
    chk("sat edge_ok", 96'(edge_ok), 96'(0));

    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("idle fe", 96'(stats_valid), 96'(0));

    // Asynchronous reset mid-frame.
    cyc(1, 0, 1, 20, 20, 'h10, 'h10, 'h10, 20, 20);
    cyc(0, 0, 1, 21, 20, 'h10, 'h10, 'h10, 0, 0);
    #2 rst = 1'b1;
    #1;
    m_clear();
    m_collect = 0;
    e_max = '0; e_min = '0; e_avg = '0; e_ok = '0; e_valid = 0;
    check_all();
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(0, 1, 1, 22, 20, 'h10, 'h10, 'h10, 0, 0);
    chk("post_rst no_strobe", 96'(stats_valid), 96'(0));

    for (int f = 0; f < 20; f++) rand_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
